// File: rtl/tick_bcd_counter_if.sv
// rtl/tick_bcd_counter_if.sv - control, tick and display signals of the tick-driven BCD counter
interface tick_bcd_counter_if #(
  parameter int DIGITS = 4
);
  logic                  tick_in;
  logic                  start;
  logic                  stop;
  logic                  clear;
  logic                  up_down;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  running;
  logic                  tick_pulse;
  logic                  wrap;

  modport master (
    output tick_in, start, stop, clear, up_down,
    input  bcd_out, running, tick_pulse, wrap
  );

  modport slave (
    input  tick_in, start, stop, clear, up_down,
    output bcd_out, running, tick_pulse, wrap
  );
endinterface

// File: rtl/tick_bcd_counter.sv
// rtl/tick_bcd_counter.sv - synchronised tick edge detector driving a gated BCD up/down counter
module tick_bcd_counter #(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  tick_bcd_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic                     prev_q, prev_d;
  logic                     tick_pulse_q, tick_pulse_d;
  logic [4*DIGITS-1:0]      bcd_q, bcd_d;
  logic                     running_q, running_d;
  logic                     wrap_q, wrap_d;

  logic                     tick_edge;
  logic                     count_en;
  logic [4*DIGITS-1:0]      bcd_step;
  logic                     step_carry;
  logic [3:0]               digit;

  // tick_in is asynchronous to clk; only the last sync stage is ever looked at.
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], bus.tick_in};
    prev_d       = sync_q[SYNC_STAGES-1];
    tick_edge    = sync_q[SYNC_STAGES-1] & ~prev_q;
    tick_pulse_d = tick_edge;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (bus.stop)  state_d = PAUSE;
      PAUSE:   if (bus.start) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (bus.clear) begin
      state_d = IDLE;
    end
    running_d = (state_d == RUN);
  end

  // Ripple increment/decrement; step_carry left set means every digit rolled over.
  always_comb begin
    bcd_step   = bcd_q;
    step_carry = 1'b1;
    digit      = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = bcd_q[4*i +: 4];
      if (step_carry) begin
        if (bus.up_down) begin
          if (digit >= 4'd9) begin
            bcd_step[4*i +: 4] = 4'd0;
          end else begin
            bcd_step[4*i +: 4] = digit + 4'd1;
            step_carry         = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            bcd_step[4*i +: 4] = 4'd9;
          end else if (digit > 4'd9) begin
            bcd_step[4*i +: 4] = 4'd8;
            step_carry         = 1'b0;
          end else begin
            bcd_step[4*i +: 4] = digit - 4'd1;
            step_carry         = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    count_en = tick_edge && (state_q == RUN) && !bus.clear && !bus.stop;
    bcd_d    = bcd_q;
    wrap_d   = 1'b0;
    if (bus.clear) begin
      bcd_d = '0;
    end else if (count_en) begin
      bcd_d  = bcd_step;
      wrap_d = step_carry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      prev_q       <= 1'b0;
      tick_pulse_q <= 1'b0;
      bcd_q        <= '0;
      running_q    <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      tick_pulse_q <= tick_pulse_d;
      bcd_q        <= bcd_d;
      running_q    <= running_d;
      wrap_q       <= wrap_d;
    end
  end

  assign bus.bcd_out    = bcd_q;
  assign bus.running    = running_q;
  assign bus.tick_pulse = tick_pulse_q;
  assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_tick_bcd_counter.sv
// tb/tb_tick_bcd_counter.sv - integer-count reference model and directed scenarios for tick_bcd_counter
module tb_tick_bcd_counter;
  localparam int DIGITS = 4;
  localparam int MODULUS = 10000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tick_bcd_counter_if #(.DIGITS(DIGITS)) bus ();

  tick_bcd_counter #(.DIGITS(DIGITS), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt = 0;
  int wrap_cnt = 0;

  // Reference: count held as a plain integer, state as 0 idle / 1 run / 2 pause.
  int       m_cnt;
  int       m_state;
  bit [2:0] m_hist;
  bit       m_rise, m_en;
  bit       e_pulse, e_wrap, e_running;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt = 0; m_state = 0; m_hist = '0;
      e_pulse = 1'b0; e_wrap = 1'b0; e_running = 1'b0;
    end else begin
      // A rise of tick_in seen two samples ago becomes countable on this edge.
      m_rise = m_hist[1] & ~m_hist[2];
      m_hist = {m_hist[1:0], bus.tick_in};
      m_en = m_rise && (m_state == 1) && !bus.clear && !bus.stop;
      e_wrap = 1'b0;
      if (bus.clear) begin
        m_cnt = 0;
      end else if (m_en) begin
        if (bus.up_down) begin
          e_wrap = (m_cnt == MODULUS - 1);
          m_cnt = (m_cnt + 1) % MODULUS;
        end else begin
          e_wrap = (m_cnt == 0);
          m_cnt = (m_cnt + MODULUS - 1) % MODULUS;
        end
      end
      if (bus.clear) m_state = 0;
      else if (m_state != 1 && bus.start) m_state = 1;
      else if (m_state == 1 && bus.stop) m_state = 2;
      e_pulse = m_rise;
      e_running = (m_state == 1);
    end
  end

  always @(negedge clk) begin
    check("bcd_out", bus.bcd_out, to_bcd(m_cnt));
    check("running", 16'(bus.running), 16'(e_running));
    check("tick_pulse", 16'(bus.tick_pulse), 16'(e_pulse));
    check("wrap", 16'(bus.wrap), 16'(e_wrap));
    if (bus.tick_pulse) pulse_cnt++;
    if (bus.wrap) wrap_cnt++;
  end

  task automatic tick();
    @(negedge clk); bus.tick_in = 1'b1;
    repeat (3) @(negedge clk);
    bus.tick_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk); bus.stop = 1'b1;
    @(negedge clk); bus.stop = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); bus.clear = 1'b1;
    @(negedge clk); bus.clear = 1'b0;
  endtask

  int p0, w0;

  initial begin
    reset = 1'b1;
    bus.tick_in = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    bus.clear = 1'b0; bus.up_down = 1'b1;
    #2 reset = 1'b0;

    // 1: reset held with tick_in toggling
    p0 = pulse_cnt;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); bus.tick_in = ~bus.tick_in;
    end
    @(negedge clk);
    check("t1_bcd", bus.bcd_out, 16'h0000);
    check("t1_running", 16'(bus.running), 16'h0);
    check("t1_pulses", 16'(pulse_cnt - p0), 16'd0);
    bus.tick_in = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (4) @(negedge clk);

    // 2: count up 12 ticks, pulse timing on the first one
    pulse_start();
    check("t2_running", 16'(bus.running), 16'h1);
    p0 = pulse_cnt;
    @(negedge clk); bus.tick_in = 1'b1;
    @(negedge clk); check("t2_pulse_e0", 16'(bus.tick_pulse), 16'h0);
    @(negedge clk); check("t2_pulse_e1", 16'(bus.tick_pulse), 16'h0);
    @(negedge clk); check("t2_pulse_e2", 16'(bus.tick_pulse), 16'h1);
    @(negedge clk); check("t2_pulse_e3", 16'(bus.tick_pulse), 16'h0);
    bus.tick_in = 1'b0;
    repeat (3) @(negedge clk);
    ticks(11);
    check("t2_bcd", bus.bcd_out, 16'h0012);
    check("t2_pulses", 16'(pulse_cnt - p0), 16'd12);

    // 3: preload 9998 by counting down, then up through the wrap
    pulse_clear();
    pulse_start();
    bus.up_down = 1'b0;
    ticks(2);
    check("t3_preload", bus.bcd_out, 16'h9998);
    bus.up_down = 1'b1;
    tick();
    check("t3_9999", bus.bcd_out, 16'h9999);
    w0 = wrap_cnt;
    tick();
    check("t3_0000", bus.bcd_out, 16'h0000);
    check("t3_wraps", 16'(wrap_cnt - w0), 16'd1);

    // 4: underflow then stop
    pulse_clear();
    pulse_start();
    bus.up_down = 1'b0;
    w0 = wrap_cnt;
    tick();
    check("t4_bcd", bus.bcd_out, 16'h9999);
    check("t4_wraps", 16'(wrap_cnt - w0), 16'd1);
    pulse_stop();
    p0 = pulse_cnt;
    ticks(3);
    check("t4_hold", bus.bcd_out, 16'h9999);
    check("t4_running", 16'(bus.running), 16'h0);
    check("t4_pulses", 16'(pulse_cnt - p0), 16'd3);

    // 5: clear/stop/start together on a tick while running
    pulse_clear();
    pulse_start();
    bus.up_down = 1'b1;
    ticks(42);
    check("t5_bcd42", bus.bcd_out, 16'h0042);
    @(negedge clk); bus.clear = 1'b1; bus.stop = 1'b1; bus.start = 1'b1;
    tick();
    bus.clear = 1'b0; bus.stop = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    check("t5_bcd", bus.bcd_out, 16'h0000);
    check("t5_running", 16'(bus.running), 16'h0);

    // 6: asynchronous reset in the middle of counting
    pulse_start();
    ticks(105);
    check("t6_bcd105", bus.bcd_out, 16'h0105);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6_async_bcd", bus.bcd_out, 16'h0000);
    check("t6_async_running", 16'(bus.running), 16'h0);
    #9 reset = 1'b1;
    p0 = pulse_cnt;
    ticks(3);
    check("t6_idle_bcd", bus.bcd_out, 16'h0000);
    check("t6_idle_pulses", 16'(pulse_cnt - p0), 16'd3);
    pulse_start();
    tick();
    check("t6_restart", bus.bcd_out, 16'h0001);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
